// File: rtl/fp_pkg.sv
// Shared definitions for the fp_add_arbiter slice.
//   FP_W       : width of an IEEE-754 single-precision operand.
//   fp_state_e : arbiter FSM states (idle, executing, result held).
package fp_pkg;

    localparam int unsigned FP_W = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } fp_state_e;

endpackage

// File: rtl/fp_rr_arbiter.sv
// Two-way round-robin arbiter.
// The grant is combinational from the request vector and the priority pointer.
// The pointer moves only when a request is actually accepted.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   req_valid : per-requester request
//   accept    : the granted request is taken this cycle
//   grant     : index of the winning requester (meaningful when any request is valid)
module fp_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic       accept,
    output logic       grant
);

    logic ptr_q;

    always_comb begin
        grant = 1'b0;
        unique case (req_valid)
            2'b11:   grant = ptr_q;
            2'b10:   grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    // After serving k, the other requester has priority on the next contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (accept) begin
            ptr_q <= ~grant;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one external combinational fp_adder between two requesters.
// A request is accepted in IDLE and its operands are latched. The adder sum is
// captured one cycle later in EXEC. The result is held in DONE until the consumer
// takes it.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   req_valid / req_ready   : per-requester handshake; ready only for the granted one in IDLE
//   req_a, req_b            : per-requester operands
//   add_in1, add_in2        : operands to the shared adder, always from the op registers
//   add_out                 : combinational adder sum
//   res_valid / res_ready   : result handshake
//   res_data, res_id        : registered sum and owning requester index
module fp_add_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ-1:0][FP_W-1:0]      req_a,
    input  logic [NREQ-1:0][FP_W-1:0]      req_b,
    output logic [FP_W-1:0]                add_in1,
    output logic [FP_W-1:0]                add_in2,
    input  logic [FP_W-1:0]                add_out,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [FP_W-1:0]                res_data,
    output logic                           res_id
);

    fp_state_e       state_q, state_d;
    logic [FP_W-1:0] op_a_q, op_b_q, res_data_q;
    logic            id_q, res_id_q;
    logic            grant;
    logic            accept;

    fp_rr_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .accept    (accept),
        .grant     (grant)
    );

    // Handshake outputs are masked by rst so nothing is offered or accepted in the reset cycle.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        res_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rst && (|req_valid)) begin
                    req_ready[grant] = 1'b1;
                    state_d          = StExec;
                end
            end
            StExec: state_d = StDone;
            StDone: begin
                res_valid = !rst;
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign accept = |req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_a_q     <= '0;
            op_b_q     <= '0;
            id_q       <= 1'b0;
            res_data_q <= '0;
            res_id_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q <= req_a[grant];
                op_b_q <= req_b[grant];
                id_q   <= grant;
            end
            if (state_q == StExec) begin
                res_data_q <= add_out;
                res_id_q   <= id_q;
            end
        end
    end

    assign add_in1  = op_a_q;
    assign add_in2  = op_b_q;
    assign res_data = res_data_q;
    assign res_id   = res_id_q;

endmodule
